// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder definitions: CNU state encodings, log2, MAG_MAX and the
// saturating absolute value shared by the check and variable node datapaths.
package ldpc_pkg;

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] EMIT    = 1'b1;

    localparam int ABS_W = 32;

    // Ceiling log2, returning at least 1 so it can size a counter directly.
    function automatic int log2(input int n);
        int r;
        r = 1;
        while ((32'sd1 <<< r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Largest magnitude representable in a w-bit two's complement message.
    function automatic int mag_max(input int w);
        return (32'sd1 <<< (w - 1)) - 32'sd1;
    endfunction

    // |v| for a w-bit value sign-extended to ABS_W; the most negative code
    // saturates to mag_max(w) instead of wrapping back to itself.
    function automatic logic [ABS_W-1:0] abs_sat(input logic signed [ABS_W-1:0] v, input int w);
        logic signed [ABS_W-1:0] lim;
        lim = mag_max(w);
        if (v < -lim) begin
            return lim;
        end else if (v < 32'sd0) begin
            return -v;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/cnu_min2_tracker.sv
// Running two-smallest magnitude tracker for the serial check node.
// Strict compares: a tie keeps the earlier edge in min1 and lands in min2.
module cnu_min2_tracker
    import ldpc_pkg::*;
#(
    parameter int mag_w = 7,
    parameter int idx_w = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             update,
    input  logic [mag_w-1:0] mag,
    input  logic [idx_w-1:0] idx,
    output logic [mag_w-1:0] min1,
    output logic [mag_w-1:0] min2,
    output logic [idx_w-1:0] min_idx
);

    localparam logic [mag_w-1:0] MAG_MAX = mag_w'(mag_max(mag_w + 1));

    logic [mag_w-1:0] min1_r;
    logic [mag_w-1:0] min2_r;
    logic [idx_w-1:0] min_idx_r;

    // Insert the new magnitude into the ordered (min1, min2) pair.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            min1_r    <= MAG_MAX;
            min2_r    <= MAG_MAX;
            min_idx_r <= {idx_w{1'b0}};
        end else if (update) begin
            if (mag < min1_r) begin
                min2_r    <= min1_r;
                min1_r    <= mag;
                min_idx_r <= idx;
            end else if (mag < min2_r) begin
                min2_r <= mag;
            end
        end
    end

    assign min1    = min1_r;
    assign min2    = min2_r;
    assign min_idx = min_idx_r;

endmodule

// File: rtl/cnu_serial.sv
// Serial min-sum check node unit: collects D q messages, then emits D r messages.
// Define CNU_OFFSET_EN for offset min-sum (emitted magnitude reduced by OFFSET).
module cnu_serial
    import ldpc_pkg::*;
#(
    parameter int data_w = 8,
    parameter int idx_w  = 8,
    parameter int D      = 6,
    parameter int OFFSET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [data_w-1:0] in_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [data_w-1:0] out_r,
    output logic [idx_w-1:0]  out_idx,
    output logic              parity_ok
);

    localparam int MAG_W = data_w - 1;
`ifdef CNU_OFFSET_EN
    localparam bit OFFSET_ON = 1'b1;
`else
    localparam bit OFFSET_ON = 1'b0;
`endif
    // A zero offset makes the offset stage an identity, so one datapath serves both builds.
    localparam logic [MAG_W-1:0] OFFSET_EFF = OFFSET_ON ? MAG_W'(OFFSET) : {MAG_W{1'b0}};
    localparam logic [idx_w-1:0] LAST_IDX   = idx_w'(D - 1);

    logic [0:0]       state_r;
    logic [idx_w-1:0] cnt_r;
    logic [idx_w-1:0] out_idx_r;
    logic [D-1:0]     signs_r;
    logic             sign_prod_r;

    logic             in_fire_s;
    logic             out_fire_s;
    logic             last_in_s;
    logic             last_out_s;
    logic             sign_s;
    logic [MAG_W-1:0] mag_s;
    logic [D-1:0]     signs_next_s;
    logic [D-1:0]     out_sel_s;
    logic             edge_sign_s;
    logic [MAG_W-1:0] min1_s;
    logic [MAG_W-1:0] min2_s;
    logic [idx_w-1:0] min_idx_s;
    logic [MAG_W-1:0] m_s;
    logic [MAG_W-1:0] m_adj_s;
    logic [data_w-1:0] r_pos_s;
    logic [data_w-1:0] out_r_s;
    logic             parity_ok_s;

    assign in_ready   = (state_r == COLLECT);
    assign out_valid  = (state_r == EMIT);
    assign in_fire_s  = in_valid && in_ready;
    assign out_fire_s = out_valid && out_ready;
    assign last_in_s  = (cnt_r == LAST_IDX);
    assign last_out_s = (out_idx_r == LAST_IDX);

    assign sign_s = in_q[data_w-1];
    assign mag_s  = MAG_W'(abs_sat(ABS_W'($signed(in_q)), data_w));

    // Decode the write slot for the incoming sign and the read slot for the outgoing edge.
    always_comb begin
        signs_next_s = signs_r;
        out_sel_s    = {D{1'b0}};
        for (int k = 0; k < D; k++) begin
            signs_next_s[k] = (cnt_r == idx_w'(k)) ? sign_s : signs_r[k];
            out_sel_s[k]    = (out_idx_r == idx_w'(k));
        end
    end

    assign edge_sign_s = |(signs_r & out_sel_s);

    cnu_min2_tracker #(
        .mag_w (MAG_W),
        .idx_w (idx_w)
    ) u_tracker (
        .clk     (clk),
        .rst     (rst),
        .clear   (out_fire_s && last_out_s),
        .update  (in_fire_s),
        .mag     (mag_s),
        .idx     (cnt_r),
        .min1    (min1_s),
        .min2    (min2_s),
        .min_idx (min_idx_s)
    );

    // Control FSM with input counter, output index and sign accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= COLLECT;
            cnt_r       <= {idx_w{1'b0}};
            out_idx_r   <= {idx_w{1'b0}};
            signs_r     <= {D{1'b0}};
            sign_prod_r <= 1'b0;
        end else begin
            case (state_r)
                COLLECT: begin
                    if (in_fire_s) begin
                        signs_r     <= signs_next_s;
                        sign_prod_r <= sign_prod_r ^ sign_s;
                        if (last_in_s) begin
                            state_r   <= EMIT;
                            cnt_r     <= {idx_w{1'b0}};
                            out_idx_r <= {idx_w{1'b0}};
                        end else begin
                            cnt_r <= cnt_r + idx_w'(1);
                        end
                    end
                end
                EMIT: begin
                    if (out_fire_s) begin
                        if (last_out_s) begin
                            state_r     <= COLLECT;
                            out_idx_r   <= {idx_w{1'b0}};
                            signs_r     <= {D{1'b0}};
                            sign_prod_r <= 1'b0;
                        end else begin
                            out_idx_r <= out_idx_r + idx_w'(1);
                        end
                    end
                end
                default: begin
                    state_r     <= COLLECT;
                    cnt_r       <= {idx_w{1'b0}};
                    out_idx_r   <= {idx_w{1'b0}};
                    signs_r     <= {D{1'b0}};
                    sign_prod_r <= 1'b0;
                end
            endcase
        end
    end

    // Extrinsic magnitude excludes the edge's own contribution, then the optional offset.
    always_comb begin
        m_s = (out_idx_r == min_idx_s) ? min2_s : min1_s;
        if (m_s > OFFSET_EFF) begin
            m_adj_s = m_s - OFFSET_EFF;
        end else begin
            m_adj_s = {MAG_W{1'b0}};
        end
    end

    assign r_pos_s = {1'b0, m_adj_s};

    // Output mux driven only from registered state; zero outside EMIT.
    always_comb begin
        if (state_r == EMIT) begin
            out_r_s     = (sign_prod_r ^ edge_sign_s) ? (-r_pos_s) : r_pos_s;
            parity_ok_s = ~sign_prod_r;
        end else begin
            out_r_s     = {data_w{1'b0}};
            parity_ok_s = 1'b0;
        end
    end

    assign out_r     = out_r_s;
    assign out_idx   = out_idx_r;
    assign parity_ok = parity_ok_s;

endmodule

// File: tb/tb_cnu_serial.sv
// Self-checking bench for cnu_serial: directed vectors plus randomized blocks
// against a direct extrinsic min-sum model (min over all other edges).
module tb_cnu_serial;

    localparam int DW  = 8;
    localparam int IW  = 8;
    localparam int DEG = 6;
    localparam int OFF = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_q;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_r;
    logic [IW-1:0] out_idx;
    logic          parity_ok;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cnu_serial #(.data_w(DW), .idx_w(IW), .D(DEG), .OFFSET(OFF)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_q      (in_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_idx   (out_idx),
        .parity_ok (parity_ok)
    );

    function automatic int sat_mag(input int v);
        if (v == -128) return 127;
        return (v < 0) ? -v : v;
    endfunction

    // r[i] = (product of other signs) * min of other magnitudes (offset when enabled).
    task automatic model(input int q[DEG], output int er[DEG], output bit ep);
        int negs;
        negs = 0;
        for (int j = 0; j < DEG; j++) negs += (q[j] < 0) ? 1 : 0;
        ep = ((negs % 2) == 0);
        for (int i = 0; i < DEG; i++) begin
            int m;
            bit s;
            m = 1000;
            s = 1'b0;
            for (int j = 0; j < DEG; j++) begin
                if (j != i) begin
                    if (sat_mag(q[j]) < m) m = sat_mag(q[j]);
                    if (q[j] < 0) s = ~s;
                end
            end
`ifdef CNU_OFFSET_EN
            m = (m > OFF) ? m - OFF : 0;
`endif
            er[i] = s ? -m : m;
        end
    endtask

    task automatic send_block(input int q[DEG], input int count);
        int waits;
        for (int k = 0; k < count; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_q     = DW'(q[k]);
            waits    = 0;
            while (in_ready !== 1'b1 && waits < 50) begin
                @(negedge clk);
                waits++;
            end
            if (in_ready !== 1'b1) begin
                tests++;
                fails++;
                $display("FAIL send_timeout in_ready=%b expected 1", in_ready);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic recv_block(input int q[DEG], input bit rand_stall, input int stall_at,
                              input int stall_len, input bit noise);
        int er[DEG];
        bit ep;
        int waits;
        int nst;
        model(q, er, ep);
        for (int i = 0; i < DEG; i++) begin
            @(negedge clk);
            if (noise) begin
                in_valid = 1'($urandom);
                in_q     = DW'($urandom);
            end
            if (i == 0) begin
                tests++;
                if (out_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL latency out_valid=%b expected 1", out_valid);
                end
            end
            nst = rand_stall ? int'($urandom_range(0, 2)) : ((i == stall_at) ? stall_len : 0);
            out_ready = 1'b0;
            for (int s = 0; s < nst; s++) begin
                tests++;
                if (out_r !== DW'(er[i]) || out_idx !== IW'(i) || in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL hold edge %0d got r=%0d idx=%0d in_ready=%b expected r=%0d idx=%0d in_ready=0",
                             i, $signed(out_r), out_idx, in_ready, er[i], i);
                end
                @(negedge clk);
            end
            out_ready = 1'b1;
            waits = 0;
            while (out_valid !== 1'b1 && waits < 50) begin
                @(negedge clk);
                waits++;
            end
            tests++;
            if (out_valid !== 1'b1) begin
                fails++;
                $display("FAIL out_timeout edge %0d out_valid=%b expected 1", i, out_valid);
            end
            tests++;
            if (out_r !== DW'(er[i])) begin
                fails++;
                $display("FAIL r[%0d] got %0d expected %0d", i, $signed(out_r), er[i]);
            end
            tests++;
            if (out_idx !== IW'(i)) begin
                fails++;
                $display("FAIL out_idx got %0d expected %0d", out_idx, i);
            end
            tests++;
            if (parity_ok !== ep || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL parity edge %0d got parity_ok=%b in_ready=%b expected parity_ok=%b in_ready=0",
                         i, parity_ok, in_ready, ep);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL return_collect got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_r !== 8'd0 ||
            out_idx !== 8'd0 || parity_ok !== 1'b0) begin
            fails++;
            $display("FAIL %s got in_ready=%b out_valid=%b out_r=%0d out_idx=%0d parity_ok=%b expected 1 0 0 0 0",
                     tag, in_ready, out_valid, out_r, out_idx, parity_ok);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_q      = 8'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset_state");
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset_idle");
    endtask

    task automatic test_vectors();
        int q[DEG];
        q = '{5, -3, 7, 2, -9, 4};
        send_block(q, DEG);
        recv_block(q, 1'b0, -1, 0, 1'b0);
        q = '{-128, -128, -128, -128, -128, -128};
        send_block(q, DEG);
        recv_block(q, 1'b0, -1, 0, 1'b0);
        q = '{4, 4, 10, 10, 10, -10};
        send_block(q, DEG);
        recv_block(q, 1'b0, -1, 0, 1'b0);
        q = '{1, 1, 1, 1, 1, 1};
        send_block(q, DEG);
        recv_block(q, 1'b0, -1, 0, 1'b0);
        q = '{0, 0, -1, 127, 0, -127};
        send_block(q, DEG);
        recv_block(q, 1'b0, -1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        int q[DEG];
        q = '{5, -3, 7, 2, -9, 4};
        send_block(q, DEG);
        recv_block(q, 1'b0, 2, 3, 1'b1);
    endtask

    task automatic test_mid_reset();
        int q[DEG];
        q = '{4, 4, 10, 10, 10, -10};
        send_block(q, 3);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("mid_reset");
        q = '{5, -3, 7, 2, -9, 4};
        send_block(q, DEG);
        recv_block(q, 1'b0, -1, 0, 1'b0);
    endtask

    task automatic test_random();
        int q[DEG];
        for (int b = 0; b < 12; b++) begin
            for (int k = 0; k < DEG; k++) begin
                case ($urandom_range(0, 3))
                    0: q[k] = int'($urandom_range(0, 4)) - 2;
                    1: q[k] = -128;
                    default: q[k] = int'($urandom_range(0, 255)) - 128;
                endcase
            end
            send_block(q, DEG);
            recv_block(q, 1'b1, -1, 0, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        int q[DEG];
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < DEG; k++) q[k] = int'($urandom_range(0, 60)) - 30;
            send_block(q, DEG);
            recv_block(q, 1'b0, -1, 0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_mid_reset();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
